// File: rtl/lsu_stage.sv
// Load/store unit stage: one outstanding bus op, byte-lane alignment and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into a flagged no-bus result.
module lsu_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_inst_type,
  input  logic [4:0]  ex_w_addr,
  input  logic [63:0] ex_result,
  input  logic [63:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [4:0]  out_w_addr,
  output logic [4:0]  out_inst_type,
  output logic        out_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] ld_q, ld_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [4:0]  out_w_addr_q, out_w_addr_d;
  logic [4:0]  out_inst_type_q, out_inst_type_d;
  logic        out_misalign_q, out_misalign_d;

  // Byte offset inside the doubleword, rounded down to the access's natural size.
  function automatic logic [2:0] lane_off(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    return a;
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] rdata, input logic [2:0] off,
                                           input logic [2:0] f3);
    logic [63:0] s;
    s = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b100:  return {56'h0, s[7:0]};
      3'b101:  return {48'h0, s[15:0]};
      3'b110:  return {32'h0, s[31:0]};
      default: return s;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return a != 3'b000;
    endcase
  endfunction
`endif

  logic       ex_mem_op;
  logic       ex_trap;
  logic [2:0] ex_off;

  assign ex_mem_op = ex_is_load | ex_is_store;
  assign ex_off    = lane_off(ex_funct3[1:0], ex_result[2:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign ex_trap   = misaligned(ex_funct3[1:0], ex_result[2:0]);
`else
  assign ex_trap   = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    drop_d          = drop_q;
    is_load_d       = is_load_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    ld_d            = ld_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    out_valid_d     = 1'b0;
    out_data_d      = out_data_q;
    out_w_addr_d    = out_w_addr_q;
    out_inst_type_d = out_inst_type_q;
    out_misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          out_w_addr_d    = ex_w_addr;
          out_inst_type_d = ex_inst_type;
          funct3_d        = ex_funct3;
          is_load_d       = ex_is_load;
          off_d           = ex_off;
          if (!ex_mem_op) begin
            out_valid_d = !flush;
            out_data_d  = ex_result;
          end else if (ex_trap) begin
            out_valid_d    = !flush;
            out_data_d     = 64'h0;
            out_misalign_d = 1'b1;
          end else begin
            state_d     = REQ;
            drop_d      = flush;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_is_store & ~ex_is_load;
            mem_addr_d  = {ex_result[63:3], 3'b000};
            mem_wmask_d = 8'h00;
            mem_wdata_d = 64'h0;
            if (ex_is_store && !ex_is_load) begin
              mem_wmask_d = size_mask(ex_funct3[1:0]) << ex_off;
              mem_wdata_d = ex_store_data << {ex_off, 3'b000};
            end
          end
        end
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      WAIT: begin
        if (flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          state_d = RESP;
          ld_d    = load_ext(mem_rdata, off_q, funct3_q);
        end
      end
      default: begin
        out_valid_d = !(drop_q || flush);
        out_data_d  = is_load_q ? ld_q : 64'h0;
        drop_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      drop_q          <= 1'b0;
      is_load_q       <= 1'b0;
      funct3_q        <= 3'b000;
      off_q           <= 3'b000;
      ld_q            <= 64'h0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 64'h0;
      mem_wdata_q     <= 64'h0;
      mem_wmask_q     <= 8'h00;
      out_valid_q     <= 1'b0;
      out_data_q      <= 64'h0;
      out_w_addr_q    <= 5'h0;
      out_inst_type_q <= 5'h0;
      out_misalign_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      drop_q          <= drop_d;
      is_load_q       <= is_load_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      ld_q            <= ld_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_w_addr_q    <= out_w_addr_d;
      out_inst_type_q <= out_inst_type_d;
      out_misalign_q  <= out_misalign_d;
    end
  end

  assign ex_ready      = (state_q == IDLE);
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_w_addr    = out_w_addr_q;
  assign out_inst_type = out_inst_type_q;
  assign out_misalign  = out_misalign_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: directed scenarios plus randomized ops against a byte-level reference model.
module tb_lsu_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_inst_type;
  logic [4:0]  ex_w_addr;
  logic [63:0] ex_result;
  logic [63:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_is_load;
  logic        ex_is_store;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic [63:0] out_data;
  logic [4:0]  out_w_addr;
  logic [4:0]  out_inst_type;
  logic        out_misalign;

  int passed = 0;
  int total  = 0;

  lsu_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_inst_type(ex_inst_type), .ex_w_addr(ex_w_addr), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_funct3(ex_funct3), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_data(out_data), .out_w_addr(out_w_addr), .out_inst_type(out_inst_type),
    .out_misalign(out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes, effective byte offset, and byte-wise extraction.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int eff_off(input logic [63:0] addr, input logic [2:0] f3);
    int o;
    o = int'(addr % 8);
    return o - (o % nbytes(f3));
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] addr, input logic [2:0] f3,
                                           input logic [63:0] rdata);
    logic [63:0] v;
    logic [63:0] b;
    int nb, off;
    nb  = nbytes(f3);
    off = eff_off(addr, f3);
    v   = 64'h0;
    for (int i = 0; i < nb; i++) begin
      b = {56'h0, rdata[8*(off+i) +: 8]};
      v = v | (b << (8*i));
    end
    if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | (~64'h0 << (8*nb));
    return v;
  endfunction

  function automatic logic [7:0] exp_mask(input logic [63:0] addr, input logic [2:0] f3);
    int m;
    m = ((1 << nbytes(f3)) - 1) << eff_off(addr, f3);
    return m[7:0];
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] addr, input logic [2:0] f3,
                                            input logic [63:0] sd);
    return sd << (8 * eff_off(addr, f3));
  endfunction

  task automatic scramble_ex();
    ex_result     = {$urandom, $urandom};
    ex_store_data = {$urandom, $urandom};
    ex_funct3     = 3'($urandom);
    ex_w_addr     = 5'($urandom);
    ex_inst_type  = 5'($urandom);
    ex_is_load    = 1'($urandom);
    ex_is_store   = 1'($urandom);
  endtask

  // fm: 0 no flush, 1 flush in first REQ cycle, 2 flush in first WAIT cycle, 3 flush in RESP.
  task automatic mem_op(input string tag, input logic [63:0] addr, input logic [63:0] sd,
                        input logic [2:0] f3, input logic ld, input logic st,
                        input int gd, input int rd, input logic [63:0] rdata, input int fm);
    logic        we;
    logic [4:0]  wa, it;
    logic [63:0] exp_out;
    we = st & ~ld;
    wa = 5'($urandom);
    it = 5'($urandom);
    exp_out = we ? 64'h0 : exp_load(addr, f3, rdata);
    ex_valid = 1'b1; ex_result = addr; ex_store_data = sd; ex_funct3 = f3;
    ex_is_load = ld; ex_is_store = st; ex_w_addr = wa; ex_inst_type = it;
    check({tag, "_ready"}, {63'h0, ex_ready}, 64'h1);
    tick();
    ex_valid = 1'b0;
    scramble_ex();
    for (int i = 0; i <= gd; i++) begin
      flush      = (fm == 1 && i == 0);
      mem_gnt    = (i == gd);
      mem_rvalid = (i == 0);
      check({tag, "_req"}, {63'h0, mem_req}, 64'h1);
      check({tag, "_we"}, {63'h0, mem_we}, {63'h0, we});
      check({tag, "_addr"}, mem_addr, {addr[63:3], 3'b000});
      check({tag, "_busy"}, {63'h0, ex_ready}, 64'h0);
      if (we) begin
        check({tag, "_wmask"}, {56'h0, mem_wmask}, {56'h0, exp_mask(addr, f3)});
        check({tag, "_wdata"}, mem_wdata, exp_wdata(addr, f3, sd));
      end
      tick();
    end
    for (int i = 0; i <= rd; i++) begin
      flush      = (fm == 2 && i == 0);
      mem_gnt    = (i == 0);
      mem_rvalid = (i == rd);
      mem_rdata  = (i == rd) ? rdata : {$urandom, $urandom};
      check({tag, "_req_drop"}, {63'h0, mem_req}, 64'h0);
      tick();
    end
    flush = (fm == 3); mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
    check({tag, "_resp_quiet"}, {63'h0, out_valid}, 64'h0);
    tick();
    flush = 1'b0;
    check({tag, "_out_valid"}, {63'h0, out_valid}, {63'h0, fm == 0});
    if (fm == 0) begin
      check({tag, "_out_data"}, out_data, exp_out);
      check({tag, "_out_waddr"}, {59'h0, out_w_addr}, {59'h0, wa});
      check({tag, "_out_itype"}, {59'h0, out_inst_type}, {59'h0, it});
      check({tag, "_misalign"}, {63'h0, out_misalign}, 64'h0);
    end
    check({tag, "_idle"}, {63'h0, ex_ready}, 64'h1);
  endtask

  task automatic nonmem_op(input string tag, input logic [63:0] res, input logic fl);
    logic [4:0] wa;
    wa = 5'($urandom);
    ex_valid = 1'b1; ex_result = res; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_w_addr = wa; ex_inst_type = 5'd3; flush = fl;
    mem_rvalid = 1'($urandom); mem_gnt = 1'($urandom);
    check({tag, "_ready"}, {63'h0, ex_ready}, 64'h1);
    tick();
    flush = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    check({tag, "_valid"}, {63'h0, out_valid}, {63'h0, !fl});
    if (!fl) begin
      check({tag, "_data"}, out_data, res);
      check({tag, "_waddr"}, {59'h0, out_w_addr}, {59'h0, wa});
    end
    check({tag, "_no_req"}, {63'h0, mem_req}, 64'h0);
  endtask

  initial begin
    logic [63:0] addr, sd, rd_v, res;
    logic [2:0]  f3;
    logic        ld, st;
    int          kind, fm;

    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 64'h0;
    scramble_ex();
    #12;
    check("rst_ready", {63'h0, ex_ready}, 64'h1);
    check("rst_req", {63'h0, mem_req}, 64'h0);
    check("rst_we", {63'h0, mem_we}, 64'h0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_wdata", mem_wdata, 64'h0);
    check("rst_wmask", {56'h0, mem_wmask}, 64'h0);
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_data", out_data, 64'h0);
    check("rst_waddr", {59'h0, out_w_addr}, 64'h0);
    check("rst_itype", {59'h0, out_inst_type}, 64'h0);
    check("rst_mis", {63'h0, out_misalign}, 64'h0);
    rst_n = 1'b1;
    tick();

    mem_op("ld_min", 64'h80000008, 64'h0, 3'b011, 1'b1, 1'b0, 0, 0, 64'h1122334455667788, 0);
    mem_op("lb", 64'h80000003, 64'h0, 3'b000, 1'b1, 1'b0, 1, 0, 64'h0000000080FF0000, 0);
    mem_op("lbu", 64'h80000003, 64'h0, 3'b100, 1'b1, 1'b0, 0, 1, 64'h0000000080FF0000, 0);
    mem_op("sh", 64'h80000006, 64'hABCD, 3'b001, 1'b0, 1'b1, 3, 0, 64'h0, 0);
    mem_op("ldst_both", 64'h80000010, 64'h55, 3'b010, 1'b1, 1'b1, 0, 0, 64'hFFFFFFFF_8000_0001, 0);
    mem_op("flush_wait", 64'h80000020, 64'h0, 3'b011, 1'b1, 1'b0, 0, 2, 64'hDEAD, 2);
    mem_op("flush_req", 64'h80000028, 64'h7, 3'b000, 1'b0, 1'b1, 2, 0, 64'h0, 1);
    mem_op("flush_resp", 64'h80000030, 64'h0, 3'b110, 1'b1, 1'b0, 0, 0, 64'h12345678_9ABCDEF0, 3);

    for (int i = 0; i < 4; i++) nonmem_op("b2b", 64'h1000 + 64'(i), 1'b0);
    nonmem_op("nm_flush", 64'hBEEF, 1'b1);
    ex_valid = 1'b0;
    tick();
    check("idle_quiet", {63'h0, out_valid}, 64'h0);

    // Reset asserted while a request is outstanding.
    ex_valid = 1'b1; ex_result = 64'h80000040; ex_funct3 = 3'b011;
    ex_is_load = 1'b1; ex_is_store = 1'b0;
    tick();
    ex_valid = 1'b0;
    check("rstreq_req", {63'h0, mem_req}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("rstreq_req_low", {63'h0, mem_req}, 64'h0);
    check("rstreq_addr", mem_addr, 64'h0);
    #3 rst_n = 1'b1;
    tick();
    check("rstreq_ready", {63'h0, ex_ready}, 64'h1);
    check("rstreq_valid", {63'h0, out_valid}, 64'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_result = 64'h80000002; ex_funct3 = 3'b010;
    ex_is_load = 1'b1; ex_is_store = 1'b0;
    tick();
    ex_valid = 1'b0;
    check("mis_valid", {63'h0, out_valid}, 64'h1);
    check("mis_flag", {63'h0, out_misalign}, 64'h1);
    check("mis_data", out_data, 64'h0);
    check("mis_req", {63'h0, mem_req}, 64'h0);
    check("mis_ready", {63'h0, ex_ready}, 64'h1);
    tick();
    check("mis_pulse", {63'h0, out_valid}, 64'h0);
`endif

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        res = {$urandom, $urandom};
        nonmem_op("rnd_nm", res, ($urandom_range(0, 7) == 0));
      end else begin
        st   = (kind == 2);
        ld   = !st || ($urandom_range(0, 7) == 0);
        f3   = st ? {1'b0, 2'($urandom)} : 3'($urandom_range(0, 6));
        addr = 64'h80000000 + 64'($urandom_range(0, 255));
`ifdef LSU_MISALIGN_TRAP_EN
        addr = addr & ~(64'(nbytes(f3)) - 64'h1);
`endif
        sd   = {$urandom, $urandom};
        rd_v = {$urandom, $urandom};
        fm   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
        mem_op("rnd_mem", addr, sd, f3, ld, st, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), rd_v, fm);
      end
    end
    ex_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
